// File: rtl/ser_pkg.sv
// Shared types and helpers for the parametrised serializer.
//   ser_state_e : serializer FSM states (PARITY only when SER_PARITY_EN is defined)
//   cnt_w()     : bit-counter width for a given word width
// Configuration macro: SER_PARITY_EN
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SER_PARITY_EN
    , PARITY
`endif
  } ser_state_e;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding register in front of the shifter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous drop of the held word (wins over push/pop)
//   push       : capture din, entry becomes full
//   pop        : release the entry; push+pop together replaces the held word
//   din / dout : word in / held word out
//   full       : entry occupied
module ser_hold_buf #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serializer_pw.sv
// Parametrised load/shift serializer: DATA_W-bit words in over valid/ready,
// one bit per clk out on sdata, MSB- or LSB-first. A one-word hold register
// lets consecutive words stream without an idle gap.
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : synchronous clear of held and in-flight word
//   in_data/in_valid/in_ready : word input handshake
//   sdata/sdata_valid/sof     : registered serial output, first-bit marker
//   busy        : shifter or hold register occupied
// Configuration macro: SER_PARITY_EN (append one parity bit per word;
// PARITY_ODD selects odd parity, ignored otherwise).
module serializer_pw
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_BIT   = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdata,
  output logic              sdata_valid,
  output logic              sof,
  output logic              busy
);

  localparam int unsigned  CW   = unsigned'(cnt_w(DATA_W));
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  ser_state_e        state;
  logic [DATA_W-1:0] shreg;     // bits still to be sent, next bit in the leading position
  logic [CW-1:0]     cnt;       // index of the bit currently on sdata

  logic [DATA_W-1:0] hold_data;
  logic              hold_full;

  logic              accept;
  logic              word_end;
  logic              load_pt;
  logic              load_hold;
  logic              load_new;
  logic              push;
  logic [DATA_W-1:0] load_word;
  logic              first_bit;
  logic [DATA_W-1:0] load_rest;
  logic              next_bit;
  logic [DATA_W-1:0] shreg_next;

`ifdef SER_PARITY_EN
  logic              par_bit;
  assign word_end = (state == PARITY);
`else
  logic              unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
  assign word_end = (state == SHIFT) && (cnt == LAST);
`endif

  assign in_ready = !hold_full;
  assign busy     = (state != IDLE) || hold_full;
  assign accept   = in_valid && in_ready;

  // At a word boundary the hold register is drained first so it is never
  // overtaken; an incoming word only bypasses it when it is empty.
  assign load_pt   = (state == IDLE) || word_end;
  assign load_hold = load_pt && hold_full;
  assign load_new  = load_pt && !hold_full && accept;
  assign push      = accept && !load_new && !flush;
  assign load_word = load_hold ? hold_data : in_data;

  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = load_word[DATA_W-1];
      load_rest  = load_word << 1;
      next_bit   = shreg[DATA_W-1];
      shreg_next = shreg << 1;
    end else begin
      first_bit  = load_word[0];
      load_rest  = load_word >> 1;
      next_bit   = shreg[0];
      shreg_next = shreg >> 1;
    end
  end

  ser_hold_buf #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (load_hold),
    .din   (in_data),
    .dout  (hold_data),
    .full  (hold_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sdata       <= IDLE_BIT;
      sdata_valid <= 1'b0;
      sof         <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else if (flush) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sdata       <= IDLE_BIT;
      sdata_valid <= 1'b0;
      sof         <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else if (load_hold || load_new) begin
      state       <= SHIFT;
      shreg       <= load_rest;
      cnt         <= '0;
      sdata       <= first_bit;
      sdata_valid <= 1'b1;
      sof         <= 1'b1;
`ifdef SER_PARITY_EN
      par_bit     <= (^load_word) ^ PARITY_ODD;
`endif
    end else begin
      sof <= 1'b0;
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef SER_PARITY_EN
            state       <= PARITY;
            sdata       <= par_bit;
            sdata_valid <= 1'b1;
`else
            state       <= IDLE;
            sdata       <= IDLE_BIT;
            sdata_valid <= 1'b0;
`endif
          end else begin
            cnt         <= cnt + 1'b1;
            shreg       <= shreg_next;
            sdata       <= next_bit;
            sdata_valid <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          sdata       <= IDLE_BIT;
          sdata_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_pw.sv
// Directed bench for serializer_pw: a 16-bit MSB-first instance (even parity),
// a 16-bit odd-parity instance sharing its inputs with IDLE_BIT=1, and an
// 8-bit LSB-first instance.
module tb_serializer_pw;
  import ser_pkg::*;

`ifdef SER_PARITY_EN
  localparam int unsigned PW = 17;
  localparam int unsigned BW = 9;
`else
  localparam int unsigned PW = 16;
  localparam int unsigned BW = 8;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready, a_sdata, a_sv, a_sof, a_busy;
  logic        c_ready, c_sdata, c_sv, c_sof, c_busy;
  logic [7:0]  b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_sdata, b_sv, b_sof, b_busy;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  logic        abits[$];
  logic        asof[$];
  int unsigned acyc[$];
  logic        cbits[$];
  logic        bbits[$];
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  serializer_pw #(.DATA_W(16), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .sdata(a_sdata), .sdata_valid(a_sv), .sof(a_sof), .busy(a_busy));

  serializer_pw #(.DATA_W(16), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .PARITY_ODD(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_data(a_data), .in_valid(a_valid),
    .in_ready(c_ready), .sdata(c_sdata), .sdata_valid(c_sv), .sof(c_sof), .busy(c_busy));

  serializer_pw #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .PARITY_ODD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .sdata(b_sdata), .sdata_valid(b_sv), .sof(b_sof), .busy(b_busy));

  // Serial capture, mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (a_sv) begin
      abits.push_back(a_sdata);
      asof.push_back(a_sof);
      acyc.push_back(cyc);
    end
    if (c_sv) cbits.push_back(c_sdata);
    if (b_sv) bbits.push_back(b_sdata);
  end

  typedef struct {
    logic [15:0] data;
    logic [15:0] serial;   // first bit sent in bit 15
    logic        par_even;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] grab16(input int unsigned base);
    logic [15:0] r;
    for (int unsigned i = 0; i < 16; i++) r[15-i] = abits[base+i];
    return r;
  endfunction

  function automatic int unsigned count_sof(input int unsigned base, input int unsigned n);
    int unsigned s = 0;
    for (int unsigned i = 0; i < n; i++) if (asof[base+i]) s++;
    return s;
  endfunction

  task automatic send_a(input logic [15:0] w);
    int unsigned n = 0;
    while (!a_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", a_ready, 1);
    a_data  = w;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w);
    b_data  = w;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    int unsigned base, cbase, n, bb;
    logic [15:0] w3[3];
    logic [7:0]  bact;
    int unsigned idx, guard;
    logic        acc, saw_stall;

    vecs[0] = '{16'hA5A5, 16'b1010010110100101, 1'b0};
    vecs[1] = '{16'h3C3C, 16'b0011110000111100, 1'b0};
    vecs[2] = '{16'h0001, 16'b0000000000000001, 1'b1};
    vecs[3] = '{16'h8000, 16'b1000000000000000, 1'b1};

    // Reset state
    repeat (2) tick();
    check("rst_sv", a_sv, 0);
    check("rst_sof", a_sof, 0);
    check("rst_ready", a_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_sdata", a_sdata, 0);
    check("rst_idle_bit_c", c_sdata, 1);
    reset = 1'b0;
    tick();

    // Single words, table-driven
    for (int unsigned v = 0; v < 4; v++) begin
      base  = abits.size();
      cbase = cbits.size();
      send_a(vecs[v].data);
      check("first_sof", a_sof, 1);
      check("first_busy", a_busy, 1);
      repeat (22) tick();
      check("word_len", abits.size() - base, PW);
      check("word_bits", grab16(base), vecs[v].serial);
      check("word_sof_cnt", count_sof(base, PW), 1);
      check("word_sof_pos", asof[base], 1);
`ifdef SER_PARITY_EN
      check("par_even", abits[base+16], vecs[v].par_even);
      check("par_odd", cbits[cbase+16], !vecs[v].par_even);
      check("par_sof", asof[base+16], 0);
`endif
      check("idle_sv", a_sv, 0);
      check("idle_sdata", a_sdata, 0);
      check("idle_sdata_c", c_sdata, 1);
      check("idle_busy", a_busy, 0);
    end

    // Back-to-back two words with in_valid held
    base    = abits.size();
    a_data  = 16'hA5A5;
    a_valid = 1'b1;
    tick();
    a_data  = 16'h3C3C;
    tick();
    a_valid = 1'b0;
    repeat (40) tick();
    check("b2b_len", abits.size() - base, 2 * PW);
    check("b2b_contig", acyc[base + 2*PW - 1] - acyc[base], 2 * PW - 1);
    check("b2b_w0", grab16(base), 16'hA5A5);
    check("b2b_w1", grab16(base + PW), 16'b0011110000111100);
    check("b2b_sof0", asof[base], 1);
    check("b2b_sof1", asof[base + PW], 1);
    check("b2b_sof_cnt", count_sof(base, 2 * PW), 2);

    // Three words pushed as fast as in_ready allows
    w3[0] = 16'hF00F; w3[1] = 16'h0FF0; w3[2] = 16'h5555;
    base = abits.size();
    idx = 0; guard = 0; saw_stall = 1'b0;
    while (idx < 3 && guard < 200) begin
      a_data  = w3[idx];
      a_valid = 1'b1;
      acc = a_ready;
      if (!acc) saw_stall = 1'b1;
      tick();
      if (acc) idx++;
      guard++;
    end
    a_valid = 1'b0;
    check("three_accepted", idx, 3);
    check("three_stall_seen", saw_stall, 1);
    repeat (60) tick();
    check("three_len", abits.size() - base, 3 * PW);
    check("three_contig", acyc[base + 3*PW - 1] - acyc[base], 3 * PW - 1);
    for (int unsigned k = 0; k < 3; k++) begin
      check("three_word", grab16(base + k * PW), w3[k]);
      check("three_sof", asof[base + k * PW], 1);
    end
    check("three_sof_cnt", count_sof(base, 3 * PW), 3);

    // LSB-first, 8-bit
    bb = bbits.size();
    send_b(8'h01);
    repeat (12) tick();
    check("lsb_len", bbits.size() - bb, BW);
    for (int unsigned i = 0; i < 8; i++) bact[7-i] = bbits[bb+i];
    check("lsb_01", bact, 8'b10000000);
`ifdef SER_PARITY_EN
    check("lsb_01_par", bbits[bb+8], 1);
`endif
    bb = bbits.size();
    send_b(8'hB4);
    repeat (12) tick();
    for (int unsigned i = 0; i < 8; i++) bact[7-i] = bbits[bb+i];
    check("lsb_b4", bact, 8'b00101101);
`ifdef SER_PARITY_EN
    check("lsb_b4_par", bbits[bb+8], 0);
`endif

    // Flush at bit 5 with a word held
    base    = abits.size();
    a_data  = 16'hFFFF;
    a_valid = 1'b1;
    tick();
    a_data  = 16'h1234;
    tick();
    a_valid = 1'b0;
    check("flush_hold_full", a_ready, 0);
    repeat (4) tick();
    flush   = 1'b1;
    a_valid = 1'b1;
    a_data  = 16'hBEEF;
    tick();
    flush   = 1'b0;
    a_valid = 1'b0;
    check("flush_sv", a_sv, 0);
    check("flush_ready", a_ready, 1);
    check("flush_busy", a_busy, 0);
    check("flush_sdata", a_sdata, 0);
    check("flush_bits_before", abits.size() - base, 6);
    n = abits.size();
    repeat (40) tick();
    check("flush_no_resume", abits.size(), n);

    // Flush while idle drops the word offered on the same edge
    n       = abits.size();
    flush   = 1'b1;
    a_valid = 1'b1;
    a_data  = 16'hFFFF;
    tick();
    flush   = 1'b0;
    a_valid = 1'b0;
    repeat (30) tick();
    check("flush_idle_drop", abits.size(), n);
    check("flush_idle_busy", a_busy, 0);

    // Reset mid-word with a word held
    a_data  = 16'hFFFF;
    a_valid = 1'b1;
    tick();
    a_data  = 16'h1234;
    tick();
    a_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("rstmid_sv", a_sv, 0);
    check("rstmid_ready", a_ready, 1);
    check("rstmid_busy", a_busy, 0);
    n = abits.size();
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check("rstmid_no_resume", abits.size(), n);

    // Still functional after reset
    base = abits.size();
    send_a(16'h3C3C);
    repeat (22) tick();
    check("post_rst_word", grab16(base), 16'h3C3C);
    check("post_rst_len", abits.size() - base, PW);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
